// File: rtl/neokeon_gamma_serial.sv
// Bit-serial Neokeon Gamma: SLICE_W bits of each word per cycle, valid/ready on both sides.
// Optional macro NEOKEON_GAMMA_SELFTEST_EN adds a second Gamma pass that checks the involution.
module neokeon_gamma_serial #(
  parameter int SLICE_W = 8
) (
  input  logic         inClk,
  input  logic         inRst,
  input  logic         inValid,
  output logic         outReady,
  input  logic [127:0] inDataState,
  output logic         outValid,
  input  logic         inReady,
  output logic [127:0] outDataState
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  ,
  output logic         outError
`endif
);

  localparam int N  = 32 / SLICE_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  localparam int LANES = 2;
`else
  localparam int LANES = 1;
`endif

  generate
    if (!(SLICE_W == 1 || SLICE_W == 2 || SLICE_W == 4 ||
          SLICE_W == 8 || SLICE_W == 16 || SLICE_W == 32)) begin : genBadSliceW
      $error("neokeon_gamma_serial: SLICE_W must be 1, 2, 4, 8, 16 or 32");
    end
  endgenerate

`ifdef NEOKEON_GAMMA_SELFTEST_EN
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t          stateReg, stateNext;
  logic [127:0]    dataReg;
  logic [CW-1:0]   cntReg;
  logic            lastSlice;
  logic [127:0]    laneIn  [LANES];
  logic [127:0]    laneOut [LANES];
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  logic [127:0]    checkReg;
  logic [127:0]    shadowReg;
  logic            errorReg;
`endif

  // Gamma on one bit column {a0,a1,a2,a3}
  function automatic logic [3:0] gammaBit(input logic [3:0] a);
    logic x0, x1, x2, x3, t;
    x0 = a[3];
    x1 = a[2];
    x2 = a[1];
    x3 = a[0];
    x1 = x1 ^ (~x3 & ~x2);
    x0 = x0 ^ (x2 & x1);
    t  = x0;
    x0 = x3;
    x3 = t;
    x2 = x2 ^ (x0 ^ x1 ^ x3);
    x1 = x1 ^ (~x3 & ~x2);
    x0 = x0 ^ (x2 & x1);
    return {x0, x1, x2, x3};
  endfunction

  assign laneIn[0] = dataReg;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  assign laneIn[1] = checkReg;
`endif

  // Each lane transforms the low slice of every word and rotates it into the top
  genvar gl, gi;
  generate
    for (gl = 0; gl < LANES; gl++) begin : genLane
      logic [SLICE_W-1:0] s0, s1, s2, s3;
      for (gi = 0; gi < SLICE_W; gi++) begin : genBit
        assign {s0[gi], s1[gi], s2[gi], s3[gi]} =
          gammaBit({laneIn[gl][96+gi], laneIn[gl][64+gi], laneIn[gl][32+gi], laneIn[gl][gi]});
      end
      if (SLICE_W == 32) begin : genWhole
        assign laneOut[gl] = {s0, s1, s2, s3};
      end else begin : genRot
        assign laneOut[gl] = {s0, laneIn[gl][127:96+SLICE_W],
                              s1, laneIn[gl][95:64+SLICE_W],
                              s2, laneIn[gl][63:32+SLICE_W],
                              s3, laneIn[gl][31:SLICE_W]};
      end
    end
  endgenerate

  assign lastSlice = (cntReg == LAST);

  always_ff @(posedge inClk) begin
    if (inRst) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE: if (inValid) stateNext = RUN;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
      RUN:   if (lastSlice) stateNext = CHECK;
      CHECK: if (lastSlice) stateNext = DONE;
`else
      RUN:   if (lastSlice) stateNext = DONE;
`endif
      DONE: if (inReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    outReady = (stateReg == IDLE);
    outValid = (stateReg == DONE);
  end

  always_ff @(posedge inClk) begin
    if (inRst) begin
      dataReg   <= '0;
      cntReg    <= '0;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
      checkReg  <= '0;
      shadowReg <= '0;
      errorReg  <= 1'b0;
`endif
    end else begin
      case (stateReg)
        IDLE: begin
          if (inValid) begin
            dataReg   <= inDataState;
            cntReg    <= '0;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
            shadowReg <= inDataState;
`endif
          end
        end
        RUN: begin
          dataReg <= laneOut[0];
          cntReg  <= lastSlice ? '0 : cntReg + 1'b1;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
          if (lastSlice) checkReg <= laneOut[0];
`endif
        end
`ifdef NEOKEON_GAMMA_SELFTEST_EN
        // Gamma is an involution: a second pass must reproduce the accepted input
        CHECK: begin
          checkReg <= laneOut[1];
          cntReg   <= lastSlice ? '0 : cntReg + 1'b1;
          if (lastSlice && (laneOut[1] != shadowReg)) errorReg <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  assign outDataState = dataReg;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  assign outError = errorReg;
`endif

endmodule

// File: tb/tb_neokeon_gamma_serial.sv
// Scoreboard bench for neokeon_gamma_serial: directed vectors, latency, backpressure, reset abort.
module tb_neokeon_gamma_serial;

  localparam int SLICE_W = 8;
  localparam int N = 32 / SLICE_W;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  localparam int LAT = 2 * N;
`else
  localparam int LAT = N;
`endif

  localparam logic [127:0] ZERO_IN  = 128'h0;
  localparam logic [127:0] ZERO_RES = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000;
  localparam logic [127:0] ONES_IN  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
  localparam logic [127:0] ONES_RES = 128'h00000000_FFFFFFFF_FFFFFFFF_00000000;
  localparam logic [127:0] VEC_IN   = 128'h6954e6d2_e262a1f4_3b1b8df3_491b3773;

  logic         clk = 1'b0;
  logic         inRst;
  logic         inValid;
  logic         outReady;
  logic [127:0] inDataState;
  logic         outValid;
  logic         inReady;
  logic [127:0] outDataState;
`ifdef NEOKEON_GAMMA_SELFTEST_EN
  logic         outError;
`endif

  int nChecks = 0;
  int nErrors = 0;
  int cyc = 0;
  int acceptCyc = 0;
  logic prevValid = 1'b0;
  logic [127:0] expQ[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  neokeon_gamma_serial #(.SLICE_W(SLICE_W)) dut (
    .inClk(clk),
    .inRst(inRst),
    .inValid(inValid),
    .outReady(outReady),
    .inDataState(inDataState),
    .outValid(outValid),
    .inReady(inReady),
    .outDataState(outDataState)
`ifdef NEOKEON_GAMMA_SELFTEST_EN
    ,
    .outError(outError)
`endif
  );

  function automatic logic [127:0] gammaModel(input logic [127:0] s);
    logic [31:0] a0, a1, a2, a3, t;
    {a0, a1, a2, a3} = s;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a0;
    a0 = a3;
    a3 = t;
    a2 = a2 ^ (a0 ^ a1 ^ a3);
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  task automatic checkWide(input string name, input logic [127:0] got, input logic [127:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic checkInt(input string name, input int got, input int want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake and checks latency
  always @(negedge clk) begin
    if (inRst === 1'b0) begin
      if (outReady === 1'b1 && inValid === 1'b1) acceptCyc = cyc + 1;
      if (outValid === 1'b1 && prevValid !== 1'b1) checkInt("latency", cyc - acceptCyc, LAT);
      if (outValid === 1'b1 && inReady === 1'b1) begin
        if (expQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("FAIL unexpected_output: got %h want none", outDataState);
        end else begin
          checkWide("result", outDataState, expQ.pop_front());
`ifdef NEOKEON_GAMMA_SELFTEST_EN
          checkInt("outError", int'(outError), 0);
`endif
        end
        $display("result %h (pending %0d)", outDataState, expQ.size());
      end
    end
    prevValid = outValid;
  end

  task automatic sendBlock(input logic [127:0] d, input logic [127:0] e, input bit expectOut);
    bit seen;
    seen = 1'b0;
    inDataState = d;
    inValid = 1'b1;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (outReady === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      nChecks++;
      nErrors++;
      $display("FAIL accept_timeout: got outReady=%b want 1", outReady);
    end
    @(posedge clk);
    if (expectOut && seen) expQ.push_back(e);
    $display("send %h", d);
    #1 inValid = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int i = 0; i < 300 && !empty; i++) begin
      @(negedge clk);
      if (expQ.size() == 0) empty = 1'b1;
    end
    if (!empty) begin
      nChecks++;
      nErrors++;
      $display("FAIL drain_timeout: got %0d pending want 0", expQ.size());
      expQ.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] vecRes;
    bit seen;
    inRst = 1'b1;
    inValid = 1'b0;
    inReady = 1'b1;
    inDataState = '0;
    repeat (2) @(posedge clk);
    #1 inRst = 1'b0;
    @(negedge clk);
    checkInt("reset_outReady", int'(outReady), 1);
    checkInt("reset_outValid", int'(outValid), 0);
    checkWide("reset_data", outDataState, 128'h0);
    @(posedge clk);
    #1;

    sendBlock(ZERO_IN, ZERO_RES, 1'b1);
    drain();
    sendBlock(ONES_IN, ONES_RES, 1'b1);
    drain();

    vecRes = gammaModel(VEC_IN);
    sendBlock(VEC_IN, vecRes, 1'b1);
    drain();
    sendBlock(vecRes, VEC_IN, 1'b1);
    drain();

    // Backpressure: result held in DONE, a second request must not be taken
    inReady = 1'b0;
    sendBlock(ONES_IN, ONES_RES, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (outValid === 1'b1) seen = 1'b1;
    end
    checkInt("bp_reach_done", int'(seen), 1);
    inDataState = ZERO_IN;
    inValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      checkInt("bp_outValid", int'(outValid), 1);
      checkInt("bp_outReady", int'(outReady), 0);
      checkWide("bp_data", outDataState, ONES_RES);
    end
    @(posedge clk);
    #1 inValid = 1'b0;
    inReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkInt("bp_idle_outReady", int'(outReady), 1);
    checkInt("bp_idle_outValid", int'(outValid), 0);
    checkWide("bp_idle_holds", outDataState, ONES_RES);
    checkInt("bp_scoreboard_empty", expQ.size(), 0);
    @(posedge clk);
    #1;

    // Reset during the second RUN cycle discards the block
    sendBlock(VEC_IN, VEC_IN, 1'b0);
    if (N > 1) begin
      @(posedge clk);
      #1;
    end
    inRst = 1'b1;
    @(posedge clk);
    #1 inRst = 1'b0;
    @(negedge clk);
    checkInt("abort_outValid", int'(outValid), 0);
    checkInt("abort_outReady", int'(outReady), 1);
    checkWide("abort_data", outDataState, 128'h0);
    @(posedge clk);
    #1;
    sendBlock(ZERO_IN, ZERO_RES, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
    $finish;
  end

endmodule
